// File: rtl/ro_freq_counter_pkg.sv
// Shared definitions for the ring-oscillator frequency counter.
//   state_e          : 2-bit FSM state encoding (IDLE, SETTLE, COUNT, DONE)
//   *_DEF localparams: default widths / timing used by the top and sub-module
package ro_freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 24;
  localparam int WIN_W_DEF       = 20;
  localparam int SETTLE_CYC_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ro_freq_counter_sync_edge.sv
// Synchronizer + rising-edge detector for the asynchronous ring-oscillator net.
//   clk        : system clock
//   rst_n      : async active-low reset, clears all flops
//   d_async    : asynchronous input (RO array output)
//   edge_pulse : one-cycle pulse when the synchronized level goes 0 -> 1
module ro_sync_edge
  import ro_freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_async};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_d_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the RO array, waits SETTLE_CYC
// cycles, then counts synchronized rising edges of ro_in for window_len cycles.
//   clk, rst_n    : clock, async active-low reset
//   start         : begin a measurement (accepted only in IDLE)
//   abort         : cancel a measurement in progress, no result
//   window_len    : counting window in clk cycles, captured on start
//   ro_in         : asynchronous oscillator output
//   ro_en         : RO array enable (SETTLE and COUNT)
//   busy          : measurement in progress (SETTLE, COUNT, DONE)
//   result        : edge count of last completed measurement
//   result_valid  : one-cycle pulse coinciding with the DONE state
//   overflow      : counter saturated during last completed measurement
module ro_freq_counter
  import ro_freq_counter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_lat_q, ovf_lat_d;
  logic             overflow_q, overflow_d;
  logic             edge_pulse;

  ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_async    (ro_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    win_len_d  = win_len_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    ovf_lat_d  = ovf_lat_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_SETTLE;
          win_len_d = window_len;
          settle_d  = SET_W'(SETTLE_CYC - 1);
          cnt_d     = '0;
          ovf_lat_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          if (win_len_q != '0) begin
            state_d = ST_COUNT;
            win_d   = win_len_q - WIN_W'(1);
          end else begin
            // Empty window: publish the freshly cleared counter.
            state_d    = ST_DONE;
            result_d   = cnt_q;
            overflow_d = ovf_lat_q;
          end
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_COUNT: begin
        if (edge_pulse) begin
          if (cnt_q == CNT_MAX) ovf_lat_d = 1'b1;
          else                  cnt_d     = cnt_q + CNT_W'(1);
        end
        // Result is latched on the way into DONE (including an edge in the
        // final COUNT cycle) so it is already stable while result_valid is high.
        if (win_q == '0) begin
          state_d    = ST_DONE;
          result_d   = cnt_d;
          overflow_d = ovf_lat_d;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort beats start and the DONE transition; published result untouched.
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      result_d   = result_q;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      win_len_q  <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      ovf_lat_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      win_len_q  <= win_len_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      ovf_lat_q  <= ovf_lat_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign ro_en        = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign overflow     = overflow_q;

endmodule
